// File: rtl/data_mem.sv
// Byte-addressable data memory / load-store unit for a single-cycle RISC-V core.
// Loads are combinational; stores commit per byte lane on the rising clock edge.

module data_mem_lane #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

module data_mem #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        illegal
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] data;
  } wr_req_t;

  logic [IDX_W-1:0]          idx;
  logic [1:0]                lane;
  logic                      active, legal, fault;
  wr_req_t                   wreq;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] rword;
  logic [7:0]                rbyte;
  logic [15:0]               rhalf;
  logic [31:0]               ext;
  logic                      unused_addr;

  assign idx         = addr[IDX_W+1:2];
  assign lane        = addr[1:0];
  assign unused_addr = ^addr[31:IDX_W+2];
  assign active      = mem_read | mem_write;

  // With both strobes up the store encoding set decides legality.
  always_comb begin
    legal = 1'b0;
    if (mem_write) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

  assign illegal    = active & ~legal;
  assign misaligned = active & legal &
                      (((funct3[1:0] == 2'b01) & lane[0]) |
                       ((funct3[1:0] == 2'b10) & (lane != 2'b00)));
  assign fault      = illegal | misaligned;

  always_comb begin
    wreq.be   = '0;
    wreq.data = write_data;
    case (funct3[1:0])
      2'b00: begin
        wreq.be   = 4'b0001 << lane;
        wreq.data = {NUM_LANES{write_data[7:0]}};
      end
      2'b01: begin
        wreq.be   = lane[1] ? 4'b1100 : 4'b0011;
        wreq.data = {2{write_data[15:0]}};
      end
      2'b10: wreq.be = 4'b1111;
      default: wreq.be = '0;
    endcase
  end

  assign lane_we = (mem_write & ~fault) ? wreq.be : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lane #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (lane_we[g]),
      .idx_i  (idx),
      .wdata_i(wreq.data[g]),
      .rdata_o(rword[g])
    );
  end

  assign rbyte = rword[lane];
  assign rhalf = lane[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};

  always_comb begin
    ext = '0;
    case (funct3)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b010:  ext = rword;
      3'b100:  ext = {24'h0, rbyte};
      3'b101:  ext = {16'h0, rhalf};
      default: ext = '0;
    endcase
  end

  assign read_data = (mem_read & ~fault) ? ext : 32'h0;
endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory and load/store unit for the single-cycle RISC-V datapath, sitting directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It performs LB/LH/LW/LBU/LHU loads combinationally and SB/SH/SW stores on the rising clock edge, with byte enables, little-endian lane placement, sign/zero extension, and misalignment and illegal-access detection. The read result feeds the write-back mux.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words; must be a power of two; memory size = 4*DEPTH_WORDS bytes.
- `IDX_W`, default 6: word-index width, equal to log2(DEPTH_WORDS).
- `clk`, input, 1: clock; all state changes on rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `mem_read`, input, 1: load access this cycle.
- `mem_write`, input, 1: store access this cycle.
- `funct3`, input, 3: access size/type, taken from the instruction.
- `addr`, input, 32: byte address, driven from ALU `alu_result`.
- `write_data`, input, 32: store data (rs2); low byte/half used for SB/SH.
- `read_data`, output, 32: extended load result.
- `misaligned`, output, 1: current access violates natural alignment.
- `illegal`, output, 1: current access has an unsupported funct3.

## Operation
- Storage: DEPTH_WORDS x 32-bit array.
  - Word index = `addr[IDX_W+1:2]`; byte lane = `addr[1:0]`.
  - `addr` bits above IDX_W+1 are ignored, so out-of-range addresses alias modulo memory size.
- Little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- Load funct3 encodings:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend half at lane 0 or 2.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Others (011, 110, 111) are illegal.
- Store funct3 encodings:
  - 000 SB: write `write_data[7:0]` to the selected lane only.
  - 001 SH: write `write_data[15:0]` to lanes 0-1 or 2-3.
  - 010 SW: write all four lanes.
  - Others are illegal.
- Alignment rules:
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]` != 0 is misaligned.
  - Byte access is never misaligned.
- `illegal` and `misaligned` are evaluated only when `mem_read` or `mem_write` is 1; both are 0 otherwise.
- If `illegal` is set, `misaligned` is 0 (illegal takes priority).
- A faulting access (misaligned or illegal):
  - A store writes no byte.
  - A load returns `read_data` = 0.
- `read_data` = 0 whenever `mem_read` = 0.
- Both `mem_read` and `mem_write` = 1:
  - Fault checks use the store encoding set.
  - `read_data` shows pre-edge contents (read-before-write).
  - The write commits at the edge.
- Untouched bytes of a word are preserved on partial stores.

## Timing
- Loads: combinational. `read_data`, `misaligned` and `illegal` are valid in the same cycle as `addr`/`funct3`, with zero-cycle latency, as required for single-cycle operation.
- Stores: committed at the rising edge of `clk` when `mem_write`=1, `rst_n`=1 and no fault. A subsequent-cycle load sees the new value.
- Reset:
  - At any rising edge with `rst_n`=0, every word clears to 32'h0 and any store in that cycle is discarded.
  - Reset overrides writes mid-sequence.
  - After reset, any load returns 0.
- Output values with `rst_n`=0 (combinational from the array and inputs):
  - `read_data` follows array contents, so it is 0 from the first edge after reset is sampled.
  - `misaligned` and `illegal` follow the input rules above.
- No handshake or stall: every access completes in one cycle. The upstream datapath must hold inputs stable across the edge for stores.
- Boundaries:
  - Address 4*DEPTH_WORDS aliases to word 0.
  - Highest word (index DEPTH_WORDS-1) is writable and readable at all lanes.
  - Address 32'hFFFF_FFFC maps to word DEPTH_WORDS-1.

## Test plan
- Reset then read:
  - Stimulus: hold `rst_n`=0 for 2 edges, release, then LW at 0x10.
  - Required: `read_data`=0, `misaligned`=0, `illegal`=0.
- Word store/load and aliasing:
  - Stimulus: SW 0x8765_43A1 to 0x20, next cycle LW 0x20.
  - Required: 0x8765_43A1. With DEPTH_WORDS=64, LW at 0x120 also returns 0x8765_43A1.
- Byte/half extension, after the word store above:
  - LB 0x20 -> 0xFFFF_FFA1; LBU 0x20 -> 0x0000_00A1.
  - LH 0x22 -> 0xFFFF_8765; LHU 0x22 -> 0x0000_8765.
- Partial store:
  - Stimulus: SB 0xCC to 0x21, SH 0x1234 to 0x22, then LW 0x20.
  - Required: 0x1234_CCA1.
- Faults:
  - SW to 0x26: `misaligned`=1 and the word is unchanged.
  - LH 0x21: `misaligned`=1, `read_data`=0.
  - Load with funct3=011: `illegal`=1, `misaligned`=0, `read_data`=0.
  - Store with funct3=100: `illegal`=1, no write.
- Simultaneous read/write and reset mid-operation:
  - Stimulus: word 0x30 holds 0x1111_1111; in one cycle assert `mem_read`, `mem_write`, SW 0x2222_2222 to 0x30.
  - Required: `read_data`=0x1111_1111 before the edge, 0x2222_2222 after.
  - Stimulus: next cycle SW 0x3333_3333 with `rst_n`=0.
  - Required: LW 0x30 returns 0.
